// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one memory controller, one transaction at a time.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of ls-over-if priority.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_ack,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              timeout_err
);

   localparam int unsigned CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic        GRANT_IF = 1'b0;
   localparam logic        GRANT_LS = 1'b1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              owner, owner_d;
   logic              grant_ls;
   logic              mem_req_d, mem_we_d, if_ack_d, ls_ack_d, busy_d, timeout_err_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, ls_rdata_d, resp_data;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;

   // On contention, favour whoever was not served last
   always_comb grant_ls = ls_req && (!if_req || (last_grant == GRANT_IF));

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= GRANT_IF;
      end else if ((state == IDLE) && (if_req || ls_req)) begin
         last_grant <= grant_ls ? GRANT_LS : GRANT_IF;
      end
   end
`else
   always_comb grant_ls = ls_req;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      owner_d       = owner;
      mem_req_d     = mem_req;
      mem_we_d      = mem_we;
      mem_addr_d    = mem_addr;
      mem_wdata_d   = mem_wdata;
      if_ack_d      = 1'b0;
      ls_ack_d      = 1'b0;
      if_rdata_d    = if_rdata;
      ls_rdata_d    = ls_rdata;
      timeout_err_d = timeout_err;
      resp_data     = mem_ack ? mem_rdata : '1;

      case (state)
         IDLE: begin
            if (if_req || ls_req) begin
               owner_d     = grant_ls ? GRANT_LS : GRANT_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = grant_ls && ls_we;
               mem_addr_d  = grant_ls ? ls_addr : if_addr;
               mem_wdata_d = grant_ls ? ls_wdata : '0;
               cnt_d       = '0;
               state_d     = ISSUE;
            end else begin
               mem_req_d = 1'b0;
            end
         end
         ISSUE: begin
            // Completion and abort share the response path; abort returns all ones
            if (mem_ack || (cnt == CNT_W'(MEM_TIMEOUT - 1))) begin
               mem_req_d = 1'b0;
               if (!mem_ack) begin
                  timeout_err_d = 1'b1;
               end
               if (owner == GRANT_LS) begin
                  ls_ack_d   = 1'b1;
                  ls_rdata_d = resp_data;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = resp_data;
               end
               state_d = RESPOND;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         owner       <= GRANT_IF;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         if_ack      <= 1'b0;
         ls_ack      <= 1'b0;
         if_rdata    <= '0;
         ls_rdata    <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         owner       <= owner_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         if_ack      <= if_ack_d;
         ls_ack      <= ls_ack_d;
         if_rdata    <= if_rdata_d;
         ls_rdata    <= ls_rdata_d;
         busy        <= busy_d;
         timeout_err <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requesters and memory.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned TMO = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, ls_req, ls_we, mem_ack;
   logic [AW-1:0] if_addr, ls_addr;
   logic [DW-1:0] ls_wdata, mem_rdata;
   logic          if_ack, ls_ack, mem_req, mem_we, busy, timeout_err;
   logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: one outstanding transaction record plus a response-cycle flag
   bit            m_active, m_resp, m_ls, m_last_ls;
   int            m_age;
   logic          e_mem_req, e_we, e_if_ack, e_ls_ack, e_busy, e_terr;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_if_rdata, e_ls_rdata, m_data;

   always @(posedge clk) begin
      if (reset) begin
         m_active = 0; m_resp = 0; m_last_ls = 0; m_age = 0;
         e_mem_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
         e_if_ack = 0; e_ls_ack = 0; e_if_rdata = '0; e_ls_rdata = '0;
         e_busy = 0; e_terr = 0;
      end else if (m_resp) begin
         m_resp = 0; e_if_ack = 0; e_ls_ack = 0; e_busy = 0;
      end else if (m_active) begin
         m_age++;
         if (mem_ack || m_age == int'(TMO)) begin
            m_data = mem_ack ? mem_rdata : 8'hFF;
            if (!mem_ack) e_terr = 1;
            if (m_ls) begin e_ls_ack = 1; e_ls_rdata = m_data; end
            else      begin e_if_ack = 1; e_if_rdata = m_data; end
            e_mem_req = 0; m_active = 0; m_resp = 1;
         end
      end else if (if_req || ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         m_ls = ls_req && (!if_req || !m_last_ls);
`else
         m_ls = ls_req;
`endif
         m_last_ls = m_ls;
         m_active = 1; m_age = 0; e_mem_req = 1; e_busy = 1;
         e_we    = m_ls ? ls_we : 1'b0;
         e_addr  = m_ls ? ls_addr : if_addr;
         e_wdata = ls_wdata;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_req", 32'(mem_req), 32'(e_mem_req));
         check("busy", 32'(busy), 32'(e_busy));
         check("if_ack", 32'(if_ack), 32'(e_if_ack));
         check("ls_ack", 32'(ls_ack), 32'(e_ls_ack));
         check("if_rdata", 32'(if_rdata), 32'(e_if_rdata));
         check("ls_rdata", 32'(ls_rdata), 32'(e_ls_rdata));
         check("timeout_err", 32'(timeout_err), 32'(e_terr));
         if (e_mem_req) begin
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
         end
      end
   end

   initial begin
      int        n, cnt, cyc, last;
      int        gaps[4];
      bit  [3:0] order;
      int unsigned ack_pct;

      reset = 1; if_req = 0; ls_req = 0; ls_we = 0; mem_ack = 0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
      step();
      chk_en = 1'b1;
      step();
      reset = 0;
      check("reset_mem_req", 32'(mem_req), 32'd0);
      check("reset_terr", 32'(timeout_err), 32'd0);
      step();

      // Store with immediate memory ack: ack two edges after the req is sampled
      ls_req = 1; ls_we = 1; ls_addr = 8'h20; ls_wdata = 8'h3C; mem_ack = 1;
      step();
      check("store_we", 32'(mem_we), 32'd1);
      check("store_wdata", 32'(mem_wdata), 32'h3C);
      step();
      check("store_ack", 32'(ls_ack), 32'd1);
      ls_req = 0; mem_ack = 0;
      step(); step();

      // Fetch-only read, memory acks on the second ISSUE edge
      if_req = 1; if_addr = 8'h10;
      step();
      check("fetch_addr", 32'(mem_addr), 32'h10);
      check("fetch_we", 32'(mem_we), 32'd0);
      step();
      mem_ack = 1; mem_rdata = 8'hA5;
      step();
      check("fetch_ack", 32'(if_ack), 32'd1);
      check("fetch_rdata", 32'(if_rdata), 32'hA5);
      check("fetch_ls_quiet", 32'(ls_ack), 32'd0);
      mem_ack = 0; if_req = 0;
      step();
      check("fetch_ack_drop", 32'(if_ack), 32'd0);
      step();

      // Contention: both requesters re-request for three grants, then the pending one finishes
      if_req = 1; ls_req = 1; ls_we = 0; if_addr = 8'h30; ls_addr = 8'h40; mem_ack = 1;
      cnt = 0; cyc = 0; last = 0; order = '0;
      while (cnt < 4 && cyc < 200) begin
         mem_rdata = 8'($urandom);
         step(); cyc++;
         if (ls_ack || if_ack) begin
            order[cnt] = ls_ack; gaps[cnt] = cyc - last; last = cyc; cnt++;
            if (ls_ack) ls_req = 0; else if_req = 0;
         end else if (cnt < 3) begin
            ls_req = 1; if_req = 1;
         end
      end
      check("contend_done", 32'(cnt), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
      check("contend_order", 32'(order), 32'b0101);
`else
      check("contend_order", 32'(order), 32'b0111);
`endif
      check("contend_first_lat", 32'(gaps[0]), 32'd2);
      check("contend_last_gap", 32'(gaps[3]), 32'd3);
      if_req = 0; ls_req = 0; mem_ack = 0;
      step(); step();

      // Stray memory ack while idle
      mem_ack = 1;
      step(); step();
      check("stray_busy", 32'(busy), 32'd0);
      check("stray_acks", 32'({if_ack, ls_ack}), 32'd0);
      mem_ack = 0;
      step();

      // Timeout on an ls read
      ls_req = 1; ls_we = 0; ls_addr = 8'h55;
      step();
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (mem_req === 1'b0) begin n = i; break; end
      end
      check("timeout_edges", 32'(n), 32'(TMO));
      check("timeout_ack", 32'(ls_ack), 32'd1);
      check("timeout_rdata", 32'(ls_rdata), 32'hFF);
      check("timeout_flag", 32'(timeout_err), 32'd1);
      ls_req = 0;
      step(); step(); step();
      check("timeout_sticky", 32'(timeout_err), 32'd1);

      // Reset mid-ISSUE, then a normal fetch
      if_req = 1; if_addr = 8'h77;
      step();
      check("pre_reset_req", 32'(mem_req), 32'd1);
      reset = 1;
      step();
      reset = 0;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_terr", 32'(timeout_err), 32'd0);
      check("rst_ack", 32'(if_ack), 32'd0);
      mem_ack = 1; mem_rdata = 8'h5A;
      step(); step();
      check("post_rst_ack", 32'(if_ack), 32'd1);
      check("post_rst_rdata", 32'(if_rdata), 32'h5A);
      if_req = 0; mem_ack = 0;
      step(); step();

      // Randomized requesters and memory with varying responsiveness
      ack_pct = 40;
      for (int c = 0; c < 4000; c++) begin
         if (c % 64 == 0) ack_pct = $urandom_range(0, 3) * 20;
         reset     = ($urandom_range(0, 399) == 0);
         mem_ack   = ($urandom_range(0, 99) < ack_pct);
         mem_rdata = 8'($urandom);
         if (if_req && if_ack) if_req = 0;
         else if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1; if_addr = 8'($urandom);
         end
         if (ls_req && ls_ack) ls_req = 0;
         else if (!ls_req && $urandom_range(0, 2) == 0) begin
            ls_req = 1; ls_we = 1'($urandom); ls_addr = 8'($urandom); ls_wdata = 8'($urandom);
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
